// File: rtl/i2c_slave_target.sv
// I2C slave target: oversampled sclk/sda, START/STOP detect, 7-bit address
// match, byte receive on writes and byte transmit on reads.
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] data_in,
    output logic       tx_load,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       busy,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX       = 3'd3,
        TX       = 3'd4,
        RX_ACK   = 3'd5,
        MACK     = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;
    logic                   w_scl, w_sda;
    logic                   w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic                   w_start, w_stop;

    state_t     r_state, w_state;
    logic [2:0] r_bitcnt, w_bitcnt;
    logic [7:0] r_shift, w_shift;
    logic       r_rw, w_rw;
    // second-half flag for ACK slots: 0 = not yet driven/sampled, 1 = done
    logic       r_phase, w_phase;
    logic       r_sda_out, w_sda_out;
    logic [7:0] r_data_out, w_data_out;
    logic       r_rx_valid, w_rx_valid;
    logic       r_tx_load, w_tx_load;
    logic       r_busy, w_busy;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_sda_rise = w_sda & ~r_sda_d;
    assign w_sda_fall = ~w_sda & r_sda_d;
    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;

    // Input synchronisers and one-cycle-delayed copies for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], sclk};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    // FSM and datapath state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_phase    <= 1'b0;
            r_sda_out  <= 1'b1;
            r_data_out <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_bitcnt   <= w_bitcnt;
            r_shift    <= w_shift;
            r_rw       <= w_rw;
            r_phase    <= w_phase;
            r_sda_out  <= w_sda_out;
            r_data_out <= w_data_out;
            r_rx_valid <= w_rx_valid;
            r_tx_load  <= w_tx_load;
            r_busy     <= w_busy;
        end
    end

    // Next-state logic: sample on scl_rise, drive on scl_fall, START/STOP override
    always_comb begin
        w_state    = r_state;
        w_bitcnt   = r_bitcnt;
        w_shift    = r_shift;
        w_rw       = r_rw;
        w_phase    = r_phase;
        w_sda_out  = r_sda_out;
        w_data_out = r_data_out;
        w_rx_valid = 1'b0;
        w_tx_load  = 1'b0;
        w_busy     = r_busy;
        case (r_state)
            IDLE: w_sda_out = 1'b1;
            ADDR: if (w_scl_rise) begin
                w_shift  = {r_shift[6:0], w_sda};
                w_bitcnt = r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    if (r_shift[6:0] == SLAVE_ADDR) begin
                        w_state = ADDR_ACK;
                        w_rw    = w_sda;
                        w_phase = 1'b0;
                    end else begin
                        w_state = IGNORE;
                    end
                end
            end
            ADDR_ACK: if (w_scl_fall) begin
                if (!r_phase) begin
                    w_sda_out = 1'b0;
                    w_phase   = 1'b1;
                end else if (!r_rw) begin
                    w_state   = RX;
                    w_sda_out = 1'b1;
                    w_bitcnt  = 3'd0;
                end else begin
                    // bit7 goes out in the load cycle, the rest follow from the shifter
                    w_state   = TX;
                    w_shift   = {data_in[6:0], 1'b0};
                    w_sda_out = data_in[7];
                    w_tx_load = 1'b1;
                    w_bitcnt  = 3'd0;
                end
            end
            RX: if (w_scl_rise) begin
                w_shift  = {r_shift[6:0], w_sda};
                w_bitcnt = r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    w_data_out = {r_shift[6:0], w_sda};
                    w_rx_valid = 1'b1;
                    w_state    = RX_ACK;
                    w_phase    = 1'b0;
                end
            end
            RX_ACK: if (w_scl_fall) begin
                if (!r_phase) begin
                    w_sda_out = 1'b0;
                    w_phase   = 1'b1;
                end else begin
                    w_sda_out = 1'b1;
                    w_state   = RX;
                    w_bitcnt  = 3'd0;
                end
            end
            TX: if (w_scl_fall) begin
                // bitcnt counts bits driven after bit7; 7 means bit0 is on the bus
                if (r_bitcnt == 3'd7) begin
                    w_sda_out = 1'b1;
                    w_state   = MACK;
                    w_phase   = 1'b0;
                end else begin
                    w_sda_out = r_shift[7];
                    w_shift   = {r_shift[6:0], 1'b0};
                    w_bitcnt  = r_bitcnt + 3'd1;
                end
            end
            MACK: begin
                if (w_scl_rise) begin
                    if (w_sda) w_state = IGNORE;
                    else       w_phase = 1'b1;
                end else if (w_scl_fall && r_phase) begin
                    w_state   = TX;
                    w_shift   = {data_in[6:0], 1'b0};
                    w_sda_out = data_in[7];
                    w_tx_load = 1'b1;
                    w_bitcnt  = 3'd0;
                end
            end
            IGNORE: w_sda_out = 1'b1;
            default: w_state = IDLE;
        endcase
        if (w_start) begin
            // any scl-edge action in this cycle is cancelled
            w_state    = ADDR;
            w_busy     = 1'b1;
            w_bitcnt   = 3'd0;
            w_shift    = r_shift;
            w_sda_out  = 1'b1;
            w_data_out = r_data_out;
            w_rx_valid = 1'b0;
            w_tx_load  = 1'b0;
        end else if (w_stop) begin
            // a byte completing in the same cycle is still delivered
            w_state   = IDLE;
            w_busy    = 1'b0;
            w_sda_out = 1'b1;
            w_tx_load = 1'b0;
        end
    end

    assign sda_out  = r_sda_out;
    assign data_out = r_data_out;
    assign rx_valid = r_rx_valid;
    assign tx_load  = r_tx_load;
    assign busy     = r_busy;
    assign state    = r_state;
endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bit-level I2C master model, table of write
// transactions plus hand-written read / Sr / STOP-in-byte / reset sequences.
module tb_i2c_slave_target;
    localparam int QT = 80;  // quarter SCL period in time units (8 clk)

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1, m_sda = 1'b1;
    logic       sclk, sda_in, sda_out, tx_load, rx_valid, busy;
    logic [7:0] data_in = 8'h00, data_out;
    logic [2:0] state;

    assign sclk   = m_scl;
    assign sda_in = m_sda & sda_out;  // open-drain bus

    i2c_slave_target #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .sda_in(sda_in), .sda_out(sda_out),
        .data_in(data_in), .tx_load(tx_load), .data_out(data_out),
        .rx_valid(rx_valid), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int         n_checks = 0, n_fail = 0;
    int         n_rxv = 0, n_txl = 0;
    logic       saw_low = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops on rx_valid, pulse counting, sda_out low tracking
    always @(negedge clk) begin
        if (sda_out === 1'b0) saw_low = 1'b1;
        if (tx_load === 1'b1) n_txl++;
        if (rx_valid === 1'b1) begin
            n_rxv++;
            if (rx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: rx_valid with data_out=%h, expected no pulse", data_out);
            end else begin
                chk("rx_byte", {24'h0, data_out}, {24'h0, rx_q.pop_front()});
            end
        end
    end

    task automatic i2c_start;
        m_sda = 1'b1; #QT; m_scl = 1'b1; #QT; m_sda = 1'b0; #QT; m_scl = 1'b0; #QT;
    endtask
    task automatic i2c_stop;
        m_sda = 1'b0; #QT; m_scl = 1'b1; #QT; m_sda = 1'b1; #QT;
    endtask
    task automatic wbit(input logic b);
        m_sda = b; #QT; m_scl = 1'b1; #(2*QT); m_scl = 1'b0; #QT;
    endtask
    task automatic rbit(output logic b);
        m_sda = 1'b1; #QT; m_scl = 1'b1; #QT; b = sda_in; #QT; m_scl = 1'b0; #QT;
    endtask
    task automatic wbyte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
    endtask
    task automatic rbyte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin rbit(b); d[i] = b; end
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_aack;  // expected bus level in address ACK slot
        logic       exp_dack;  // expected bus level in data ACK slot
        logic       exp_rx;    // byte should be delivered
    } vec_t;

    initial begin
        vec_t       tbl[5];
        logic       a;
        logic [7:0] d;
        int         rxv0, txl0;
        logic [7:0] last_rx;

        tbl[0] = '{7'h2A, 8'hF6, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{7'h15, 8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{7'h2A, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{7'h2A, 8'h81, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{7'h2B, 8'h5A, 1'b1, 1'b1, 1'b0};
        last_rx = 8'h00;

        // reset values
        #22;
        chk("rst_sda_out", sda_out, 1'b1);
        chk("rst_state", state, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        rst = 1'b1;
        #QT;

        // table-driven write transactions
        foreach (tbl[k]) begin
            saw_low = 1'b0;
            rxv0 = n_rxv;
            i2c_start;
            chk("start_busy", busy, 1'b1);
            chk("start_state", state, 3'd1);
            wbyte({tbl[k].addr, 1'b0});
            rbit(a);
            chk("addr_ack", a, tbl[k].exp_aack);
            if (tbl[k].exp_rx) rx_q.push_back(tbl[k].data);
            wbyte(tbl[k].data);
            rbit(a);
            chk("data_ack", a, tbl[k].exp_dack);
            if (!tbl[k].exp_rx) begin
                chk("miss_state", state, 3'd7);
                chk("miss_busy", busy, 1'b1);
                chk("miss_sda_low", saw_low, 1'b0);
                chk("miss_rx_count", n_rxv - rxv0, 0);
            end else begin
                chk("wr_rx_count", n_rxv - rxv0, 1);
                last_rx = tbl[k].data;
            end
            i2c_stop;
            #QT;
            chk("stop_busy", busy, 1'b0);
            chk("stop_state", state, 3'd0);
            chk("stop_data_out", data_out, last_rx);
        end

        // read: A5 with master ACK, 3C with master NACK
        txl0 = n_txl;
        data_in = 8'hA5; tx_q.push_back(8'hA5);
        i2c_start;
        wbyte({7'h2A, 1'b1});
        rbit(a);
        chk("rd_addr_ack", a, 1'b0);
        rbyte(d);
        chk("rd_byte0", d, tx_q.pop_front());
        data_in = 8'h3C; tx_q.push_back(8'h3C);
        wbit(1'b0);
        rbyte(d);
        chk("rd_byte1", d, tx_q.pop_front());
        wbit(1'b1);
        chk("rd_nack_state", state, 3'd7);
        chk("rd_tx_load_cnt", n_txl - txl0, 2);
        i2c_stop;
        #QT;
        chk("rd_stop_state", state, 3'd0);

        // repeated START: write 0x11, then Sr into a read
        i2c_start;
        wbyte({7'h2A, 1'b0});
        rbit(a);
        rx_q.push_back(8'h11);
        wbyte(8'h11);
        rbit(a);
        chk("sr_wr_ack", a, 1'b0);
        i2c_start;
        data_in = 8'hC3; tx_q.push_back(8'hC3);
        wbyte({7'h2A, 1'b1});
        rbit(a);
        chk("sr_addr_ack", a, 1'b0);
        chk("sr_state_tx", state, 3'd4);
        chk("sr_data_out", data_out, 8'h11);
        rbyte(d);
        chk("sr_rd_byte", d, tx_q.pop_front());
        wbit(1'b1);
        i2c_stop;
        #QT;

        // STOP after 4 bits of a received byte
        rxv0 = n_rxv;
        i2c_start;
        wbyte({7'h2A, 1'b0});
        rbit(a);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        i2c_stop;
        #QT;
        chk("pstop_state", state, 3'd0);
        chk("pstop_busy", busy, 1'b0);
        chk("pstop_data_out", data_out, 8'h11);
        chk("pstop_rx_count", n_rxv - rxv0, 0);

        // async reset while the target holds the address ACK low
        i2c_start;
        wbyte({7'h2A, 1'b0});
        m_sda = 1'b1; #QT; m_scl = 1'b1; #QT;
        chk("pre_rst_ack_low", sda_out, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_sda_out", sda_out, 1'b1);
        chk("mid_rst_state", state, 3'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_data_out", data_out, 8'h00);
        chk("mid_rst_rx_valid", rx_valid, 1'b0);
        chk("mid_rst_tx_load", tx_load, 1'b0);
        #9;
        m_scl = 1'b1; m_sda = 1'b1;
        #QT;
        rst = 1'b1;
        #QT;

        // recovery after reset
        i2c_start;
        wbyte({7'h2A, 1'b0});
        rbit(a);
        chk("post_rst_ack", a, 1'b0);
        rx_q.push_back(8'h77);
        wbyte(8'h77);
        rbit(a);
        i2c_stop;
        #QT;
        chk("post_rst_data_out", data_out, 8'h77);
        chk("rx_queue_drained", rx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
